// File: rtl/mem_req_arbiter_if.sv
// Handshake bundle between the fetch/load-store clients, the arbiter and the shared memory bus.
// The arbiter uses the slave modport; the client/bus environment uses master.
interface mem_req_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_cancel;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   modport slave (
      input  inst_req, inst_addr, inst_cancel,
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  bus_addr_ok, bus_data_ok, bus_rdata,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
   );

   modport master (
      output inst_req, inst_addr, inst_cancel,
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output bus_addr_ok, bus_data_ok, bus_rdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction fetch and data requests onto one shared memory bus,
// data first with a starvation limit for fetch, one transaction outstanding.
module mem_req_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                aclk,
   input  logic                reset,
   mem_req_arbiter_if.slave    bus_if
);

   typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT} state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     r_state;
   state_t     w_next;
   logic       r_drop;
   logic       w_drop_nxt;
   logic [2:0] r_starve_cnt;
   logic [2:0] w_starve_nxt;
   logic       w_inst_vld;
   logic       w_grant_inst;
   logic       w_grant_data;

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_drop       <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_next;
         r_drop       <= w_drop_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_drop_nxt   = r_drop;
      w_starve_nxt = r_starve_cnt;
      w_inst_vld   = bus_if.inst_req & ~bus_if.inst_cancel;
      w_grant_inst = 1'b0;
      w_grant_data = 1'b0;

      bus_if.inst_addr_ok = 1'b0;
      bus_if.inst_data_ok = 1'b0;
      bus_if.inst_rdata   = '0;
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      bus_if.data_rdata   = '0;
      bus_if.bus_req      = 1'b0;
      bus_if.bus_wr       = 1'b0;
      bus_if.bus_size     = '0;
      bus_if.bus_addr     = '0;
      bus_if.bus_wdata    = '0;
      bus_if.bus_wstrb    = '0;

      // Outputs are held at zero for the whole reset cycle, not just after the edge.
      if (!reset) begin
         unique case (r_state)
            IDLE: begin
               w_grant_inst   = w_inst_vld & (~bus_if.data_req | (r_starve_cnt == STARVE_LIM));
               w_grant_data   = bus_if.data_req & ~w_grant_inst;
               bus_if.bus_req = bus_if.data_req | w_inst_vld;
               if (w_grant_inst) begin
                  bus_if.bus_size     = 2'b10;
                  bus_if.bus_addr     = bus_if.inst_addr;
                  bus_if.inst_addr_ok = bus_if.bus_addr_ok;
                  if (bus_if.bus_addr_ok) begin
                     w_next       = INST_WAIT;
                     w_starve_nxt = '0;
                  end
               end else if (w_grant_data) begin
                  bus_if.bus_wr       = bus_if.data_wr;
                  bus_if.bus_size     = bus_if.data_size;
                  bus_if.bus_addr     = bus_if.data_addr;
                  bus_if.bus_wdata    = bus_if.data_wdata;
                  bus_if.bus_wstrb    = bus_if.data_wstrb;
                  bus_if.data_addr_ok = bus_if.bus_addr_ok;
                  if (bus_if.bus_addr_ok) begin
                     w_next = DATA_WAIT;
                     if (w_inst_vld && (r_starve_cnt != STARVE_LIM))
                        w_starve_nxt = r_starve_cnt + 3'd1;
                  end
               end
            end
            INST_WAIT: begin
               bus_if.inst_rdata   = bus_if.bus_rdata;
               bus_if.inst_data_ok = bus_if.bus_data_ok & ~r_drop & ~bus_if.inst_cancel;
               if (bus_if.bus_data_ok) begin
                  w_next     = IDLE;
                  w_drop_nxt = 1'b0;
               end else if (bus_if.inst_cancel) begin
                  w_drop_nxt = 1'b1;
               end
            end
            DATA_WAIT: begin
               bus_if.data_rdata   = bus_if.bus_rdata;
               bus_if.data_data_ok = bus_if.bus_data_ok;
               if (bus_if.bus_data_ok)
                  w_next = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

endmodule
